// File: rtl/u109_pkg.sv
// Shared definitions for the U109 68040-to-PCI bridge cycle logic.
//   term_state_t  : cycle-termination FSM states
//   *_DEF         : default PCI wait limits
package u109_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEVWAIT,
    DATAWAIT,
    ACK,
    RETRY,
    ABORT,
    RECOVER
  } term_state_t;

  // Clocks after the address phase with no DEVSELn before a master abort.
  localparam int unsigned DEVSEL_TO_DEF = 5;
  // Clocks after DEVSELn with no TRDYn/STOPn before a target-latency abort.
  localparam int unsigned TRDY_TO_DEF   = 16;
  // Consecutive target retries tolerated before TEAn.
  localparam int unsigned MAX_RETRY_DEF = 8;

endpackage

// File: rtl/u109_wait_counter.sv
// Clearable, enabled, saturating wait counter with a terminal-count compare.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous clear (wins over i_en)
//   i_en           : count this clock
//   i_limit        : runtime terminal count
//   o_tc           : the count reaches i_limit on this enabled clock
module u109_wait_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_inc;

  // Saturate at all-ones instead of wrapping.
  always_comb begin
    w_inc = r_count;
    if (r_count != '1) w_inc = r_count + 1'b1;
  end

  // Compare against the incremented value so the FSM sees the timeout on the
  // same edge the counter reaches the limit.
  assign o_tc = i_en && !i_clr && (w_inc >= i_limit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= w_inc;
  end

endmodule

// File: rtl/u109_cycle_termination.sv
// U109 cycle termination: watches the PCI target response of a bridged
// 68040 cycle and produces the 68040 termination.
//   CLKP, RESETn          : PCI clock, async active-low reset
//   PCICYCLEn, ADDR_PHASE : bridged-cycle request / address-clock pulse
//   RnW                   : direction, latched with the address phase
//   DEVSELn, TRDYn, STOPn : PCI target response
//   IRDYn                 : initiator ready driven by U109
//   TACKn, TEAn           : registered 68040 acknowledge / error
//   DLATCH                : read-data capture strobe (TRDY clock)
//   RETRY_REQ             : re-issue the address phase
//   CYCLE_DONE            : bus released, PCI state machine returns to idle
module u109_cycle_termination
  import u109_pkg::*;
#(
  parameter int unsigned DEVSEL_TO = DEVSEL_TO_DEF,
  parameter int unsigned TRDY_TO   = TRDY_TO_DEF,
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
  parameter int unsigned CNT_W     = 5
) (
  input  logic CLKP,
  input  logic RESETn,
  input  logic PCICYCLEn,
  input  logic ADDR_PHASE,
  input  logic RnW,
  input  logic DEVSELn,
  input  logic TRDYn,
  input  logic STOPn,
  input  logic IRDYn,
  output logic TACKn,
  output logic TEAn,
  output logic DLATCH,
  output logic RETRY_REQ,
  output logic CYCLE_DONE
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  term_state_t        r_state, w_next;
  logic               r_rnw;
  logic [RETRY_W-1:0] r_retry_cnt;
  logic               r_tackn, r_tean, r_cycle_done;
  logic               w_dlatch, w_retry_req;
  logic               w_cnt_clr, w_cnt_en, w_tc;
  logic [CNT_W-1:0]   w_limit;
  logic               w_abandon;

  assign w_cnt_clr = (r_state == IDLE) || ((r_state == DEVWAIT) && !DEVSELn);
  assign w_cnt_en  = (r_state == DEVWAIT) || ((r_state == DATAWAIT) && !IRDYn);
  assign w_limit   = (r_state == DEVWAIT) ? CNT_W'(DEVSEL_TO) : CNT_W'(TRDY_TO);
  assign w_abandon = PCICYCLEn && ((r_state == DEVWAIT) || (r_state == DATAWAIT));

  u109_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .i_clk   (CLKP),
    .i_rst_n (RESETn),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next      = r_state;
    w_dlatch    = 1'b0;
    w_retry_req = 1'b0;
    case (r_state)
      IDLE:     if (ADDR_PHASE && !PCICYCLEn) w_next = DEVWAIT;
      DEVWAIT: begin
        if (PCICYCLEn)     w_next = RECOVER;
        else if (!DEVSELn) w_next = DATAWAIT;
        else if (w_tc)     w_next = ABORT;
      end
      DATAWAIT: begin
        if (PCICYCLEn) w_next = RECOVER;
        else if (!IRDYn) begin
          if (!TRDYn) begin
            w_next   = ACK;
            w_dlatch = r_rnw;
          end
          // Retry keeps DEVSELn asserted; STOPn with DEVSELn released is a
          // target abort.
          else if (!STOPn && !DEVSELn) w_next = RETRY;
          else if (!STOPn)             w_next = ABORT;
          else if (w_tc)               w_next = ABORT;
        end
      end
      ACK:      w_next = RECOVER;
      RETRY: begin
        if (r_retry_cnt == RETRY_LAST) w_next = ABORT;
        else begin
          w_next      = IDLE;
          w_retry_req = 1'b1;
        end
      end
      ABORT:    w_next = RECOVER;
      RECOVER:  if (PCICYCLEn) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLKP or negedge RESETn) begin
    if (!RESETn) begin
      r_state      <= IDLE;
      r_rnw        <= 1'b0;
      r_retry_cnt  <= '0;
      r_tackn      <= 1'b1;
      r_tean       <= 1'b1;
      r_cycle_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && (w_next == DEVWAIT)) r_rnw <= RnW;
      // An abandoned cycle also forgets its retry history.
      if ((r_state == ACK) || (r_state == ABORT) || w_abandon)
        r_retry_cnt <= '0;
      else if (w_retry_req)
        r_retry_cnt <= r_retry_cnt + 1'b1;
      r_tackn      <= (w_next != ACK);
      r_tean       <= (w_next != ABORT);
      r_cycle_done <= (w_next == RECOVER) && (r_state != RECOVER);
    end
  end

  assign TACKn      = r_tackn;
  assign TEAn       = r_tean;
  assign CYCLE_DONE = r_cycle_done;
  assign DLATCH     = w_dlatch;
  assign RETRY_REQ  = w_retry_req;

endmodule

// File: tb/tb_u109_cycle_termination.sv
module tb_u109_cycle_termination;

  logic CLKP, RESETn, PCICYCLEn, ADDR_PHASE, RnW;
  logic DEVSELn, TRDYn, STOPn, IRDYn;
  logic TACKn, TEAn, DLATCH, RETRY_REQ, CYCLE_DONE;

  localparam int EV_DLATCH = 1;
  localparam int EV_TACK   = 2;
  localparam int EV_TEA    = 3;
  localparam int EV_RETRY  = 4;
  localparam int EV_DONE   = 5;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_q[$];
  int obs_q[$];

  u109_cycle_termination #(
    .DEVSEL_TO (5),
    .TRDY_TO   (16),
    .MAX_RETRY (8),
    .CNT_W     (5)
  ) dut (
    .CLKP       (CLKP),
    .RESETn     (RESETn),
    .PCICYCLEn  (PCICYCLEn),
    .ADDR_PHASE (ADDR_PHASE),
    .RnW        (RnW),
    .DEVSELn    (DEVSELn),
    .TRDYn      (TRDYn),
    .STOPn      (STOPn),
    .IRDYn      (IRDYn),
    .TACKn      (TACKn),
    .TEAn       (TEAn),
    .DLATCH     (DLATCH),
    .RETRY_REQ  (RETRY_REQ),
    .CYCLE_DONE (CYCLE_DONE)
  );

  initial begin
    CLKP = 1'b0;
    forever #5 CLKP = ~CLKP;
  end

  always @(posedge CLKP) cyc <= cyc + 1;

  // Output events observed mid-cycle, encoded as cycle*8 + event code.
  always @(negedge CLKP) begin
    if (RESETn === 1'b1) begin
      if (DLATCH === 1'b1)     obs_q.push_back(cyc * 8 + EV_DLATCH);
      if (TACKn === 1'b0)      obs_q.push_back(cyc * 8 + EV_TACK);
      if (TEAn === 1'b0)       obs_q.push_back(cyc * 8 + EV_TEA);
      if (RETRY_REQ === 1'b1)  obs_q.push_back(cyc * 8 + EV_RETRY);
      if (CYCLE_DONE === 1'b1) obs_q.push_back(cyc * 8 + EV_DONE);
    end
  end

  task automatic tick();
    @(posedge CLKP);
    #1;
  endtask

  task automatic expect_ev(input int c, input int code);
    exp_q.push_back(c * 8 + code);
  endtask

  task automatic chk(input string tag, input logic obs, input logic want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  task automatic check_events(input string tag);
    int e, o, n_obs, n_exp;
    n_obs = obs_q.size();
    n_exp = exp_q.size();
    n_tests++;
    assert (n_obs === n_exp) else begin
      n_fail++;
      $error("FAIL %s event count: observed %0d expected %0d", tag, n_obs, n_exp);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_tests++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s event: observed cyc %0d code %0d expected cyc %0d code %0d",
               tag, o / 8, o % 8, e / 8, e % 8);
      end
    end
    obs_q.delete();
  endtask

  // One address phase in c0; DEVSELn low from dev_at on, TRDYn/STOPn low only
  // in their cycle, IRDYn high for ih_len cycles from ih_from.
  task automatic txn(input int dev_at, input int trdy_at, input int stop_at,
                     input int ih_from, input int ih_len, input int len,
                     output int base);
    base = cyc;
    for (int n = 0; n < len; n++) begin
      ADDR_PHASE = (n == 0);
      DEVSELn    = !(dev_at >= 0 && n >= dev_at);
      TRDYn      = !(n == trdy_at);
      STOPn      = !(n == stop_at);
      IRDYn      = (n >= ih_from) && (n < ih_from + ih_len);
      tick();
    end
    ADDR_PHASE = 1'b0;
    DEVSELn    = 1'b1;
    TRDYn      = 1'b1;
    STOPn      = 1'b1;
    IRDYn      = 1'b0;
  endtask

  task automatic finish_cycle();
    PCICYCLEn = 1'b1;
    tick();
    tick();
    PCICYCLEn = 1'b0;
    tick();
  endtask

  initial begin
    int b;
    RESETn = 1'b0; PCICYCLEn = 1'b1; ADDR_PHASE = 1'b0; RnW = 1'b0;
    DEVSELn = 1'b1; TRDYn = 1'b1; STOPn = 1'b1; IRDYn = 1'b0;
    #12;
    chk("rst_tackn", TACKn, 1'b1);
    chk("rst_tean", TEAn, 1'b1);
    chk("rst_dlatch", DLATCH, 1'b0);
    chk("rst_retry", RETRY_REQ, 1'b0);
    chk("rst_done", CYCLE_DONE, 1'b0);
    tick(); tick();
    RESETn = 1'b1;
    tick();
    obs_q.delete();

    // Medium-decode read, then held PCICYCLEn ignores a new address phase.
    PCICYCLEn = 1'b0; RnW = 1'b1;
    tick();
    txn(2, 5, -1, -1, 0, 8, b);
    expect_ev(b + 5, EV_DLATCH);
    expect_ev(b + 6, EV_TACK);
    expect_ev(b + 7, EV_DONE);
    repeat (4) tick();
    txn(2, 5, -1, -1, 0, 8, b);
    repeat (2) tick();
    check_events("read_medium");
    finish_cycle();

    // Write: no DLATCH.
    RnW = 1'b0;
    txn(2, 5, -1, -1, 0, 8, b);
    expect_ev(b + 6, EV_TACK);
    expect_ev(b + 7, EV_DONE);
    check_events("write_medium");
    finish_cycle();

    // Master abort.
    txn(-1, -1, -1, -1, 0, 10, b);
    expect_ev(b + 6, EV_TEA);
    expect_ev(b + 7, EV_DONE);
    check_events("master_abort");
    finish_cycle();

    // Three retries then completion.
    for (int i = 0; i < 3; i++) begin
      txn(1, -1, 3, -1, 0, 5, b);
      expect_ev(b + 4, EV_RETRY);
    end
    txn(1, 3, -1, -1, 0, 7, b);
    expect_ev(b + 4, EV_TACK);
    expect_ev(b + 5, EV_DONE);
    check_events("retry3_ack");
    finish_cycle();

    // Eight retries: the eighth terminates with TEAn.
    for (int i = 0; i < 8; i++) begin
      txn(1, -1, 3, -1, 0, 5, b);
      if (i < 7) expect_ev(b + 4, EV_RETRY);
      else begin
        expect_ev(b + 5, EV_TEA);
        expect_ev(b + 6, EV_DONE);
      end
    end
    repeat (3) tick();
    check_events("retry8_abort");
    finish_cycle();

    // Target latency timeout, then the same with 4 IRDYn-high clocks.
    txn(1, -1, -1, -1, 0, 22, b);
    expect_ev(b + 18, EV_TEA);
    expect_ev(b + 19, EV_DONE);
    check_events("trdy_timeout");
    finish_cycle();
    txn(1, -1, -1, 5, 4, 26, b);
    expect_ev(b + 22, EV_TEA);
    expect_ev(b + 23, EV_DONE);
    check_events("trdy_timeout_irdy_hold");
    finish_cycle();

    // TRDYn and STOPn together: acknowledge, not retry.
    RnW = 1'b1;
    txn(1, 3, 3, -1, 0, 6, b);
    expect_ev(b + 3, EV_DLATCH);
    expect_ev(b + 4, EV_TACK);
    expect_ev(b + 5, EV_DONE);
    check_events("trdy_stop_same");
    finish_cycle();

    // PCICYCLEn negated during DATAWAIT: CYCLE_DONE only.
    b = cyc;
    ADDR_PHASE = 1'b1; tick();
    ADDR_PHASE = 1'b0; DEVSELn = 1'b0; tick();
    PCICYCLEn = 1'b1;
    expect_ev(b + 3, EV_DONE);
    repeat (3) tick();
    DEVSELn = 1'b1; PCICYCLEn = 1'b0;
    tick();
    check_events("abandon");

    // Asynchronous reset in DATAWAIT with DLATCH active.
    b = cyc;
    ADDR_PHASE = 1'b1; tick();
    ADDR_PHASE = 1'b0; DEVSELn = 1'b0; tick();
    TRDYn = 1'b0;
    #2;
    chk("dlatch_before_reset", DLATCH, 1'b1);
    RESETn = 1'b0;
    #1;
    chk("rstdw_tackn", TACKn, 1'b1);
    chk("rstdw_tean", TEAn, 1'b1);
    chk("rstdw_dlatch", DLATCH, 1'b0);
    chk("rstdw_retry", RETRY_REQ, 1'b0);
    chk("rstdw_done", CYCLE_DONE, 1'b0);
    TRDYn = 1'b1; DEVSELn = 1'b1;
    tick(); tick();
    RESETn = 1'b1;
    repeat (3) tick();
    check_events("reset_datawait");

    // Asynchronous reset while TACKn is low.
    b = cyc;
    ADDR_PHASE = 1'b1; tick();
    ADDR_PHASE = 1'b0; DEVSELn = 1'b0; tick();
    TRDYn = 1'b0; tick();
    TRDYn = 1'b1; DEVSELn = 1'b1;
    expect_ev(b + 2, EV_DLATCH);
    #2;
    chk("tackn_before_reset", TACKn, 1'b0);
    RESETn = 1'b0;
    #1;
    chk("rstack_tackn", TACKn, 1'b1);
    chk("rstack_tean", TEAn, 1'b1);
    chk("rstack_done", CYCLE_DONE, 1'b0);
    tick();
    RESETn = 1'b1;
    repeat (3) tick();
    check_events("reset_ack");

    // Clean cycle after reset.
    RnW = 1'b0;
    txn(1, 2, -1, -1, 0, 6, b);
    expect_ev(b + 3, EV_TACK);
    expect_ev(b + 4, EV_DONE);
    check_events("after_reset");
    finish_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
